dcache_ctrl: RTL and testbench

- Blocking miss/writeback controller in front of the 4-way Dcache.
- Arbitrates one load port and one store port from the LSQ into single cache lookups.
- On a miss: writes back a dirty LRU victim over the memory bus, fetches the missing 8-byte block (loads only), then installs the line with wr1_from_mem so the Dcache LRU advances.
- One outstanding miss; both request ports stall while it is serviced.

---
 rtl/dcache_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Blocking miss/writeback controller for the 4-way Dcache: arbitrates one load and one
// store port, writes back dirty victims, fetches load misses and installs lines.
module dcache_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_TAG_W   = 4,
  parameter int LD_PRIORITY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ld_req_valid,
  input  logic [ADDR_W-1:0]    ld_req_addr,
  output logic                 ld_req_ready,
  output logic                 ld_resp_valid,
  output logic [DATA_W-1:0]    ld_resp_data,
  input  logic                 st_req_valid,
  input  logic [ADDR_W-1:0]    st_req_addr,
  input  logic [DATA_W-1:0]    st_req_data,
  output logic                 st_req_ready,
  output logic [ADDR_W-1:0]    dc_rd1_addr,
  input  logic                 dc_rd1_hit,
  input  logic [DATA_W-1:0]    dc_rd1_data,
  output logic                 dc_wr1_en,
  output logic                 dc_wr1_from_mem,
  output logic                 dc_wr1_dirty,
  output logic                 dc_wr1_valid,
  output logic [ADDR_W-1:0]    dc_wr1_addr,
  output logic [DATA_W-1:0]    dc_wr1_data,
  input  logic                 dc_evicted_valid,
  input  logic                 dc_evicted_dirty,
  input  logic [ADDR_W-1:0]    dc_evicted_addr,
  input  logic [DATA_W-1:0]    dc_evicted_data,
  output logic [1:0]           proc2mem_command,
  output logic [ADDR_W-1:0]    proc2mem_addr,
  output logic [DATA_W-1:0]    proc2mem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  input  logic [DATA_W-1:0]    mem2proc_data,
  output logic                 busy
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_ALLOC, S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic                   is_ld_q, is_ld_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      st_data_q, st_data_d;
  logic [ADDR_W-1:0]      vic_addr_q, vic_addr_d;
  logic [DATA_W-1:0]      vic_data_q, vic_data_d;
  logic                   vic_dirty_q, vic_dirty_d;
  logic                   vic_valid_q, vic_valid_d;
  logic [MEM_TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   resp_vld_q, resp_vld_d;

  logic                   sel_ld, sel_st;
  logic [ADDR_W-1:0]      sel_addr;
  logic                   unused_addr_lsbs;

  // Block offsets are meaningless with one 8-byte block per line.
  assign unused_addr_lsbs = ^{ld_req_addr[2:0], st_req_addr[2:0], dc_evicted_addr[2:0]};

  assign sel_ld   = ld_req_valid && ((LD_PRIORITY != 0) || !st_req_valid);
  assign sel_st   = st_req_valid && !sel_ld;
  assign sel_addr = sel_ld ? {ld_req_addr[ADDR_W-1:3], 3'b000} :
                    sel_st ? {st_req_addr[ADDR_W-1:3], 3'b000} : '0;

  assign busy          = (state_q != S_IDLE);
  assign ld_resp_valid = resp_vld_q || (state_q == S_RESP);
  assign ld_resp_data  = ld_resp_valid ? data_q : '0;

  always_comb begin
    state_d          = state_q;
    is_ld_d          = is_ld_q;
    addr_d           = addr_q;
    st_data_d        = st_data_q;
    vic_addr_d       = vic_addr_q;
    vic_data_d       = vic_data_q;
    vic_dirty_d      = vic_dirty_q;
    vic_valid_d      = vic_valid_q;
    tag_d            = tag_q;
    data_d           = data_q;
    resp_vld_d       = 1'b0;
    ld_req_ready     = 1'b0;
    st_req_ready     = 1'b0;
    dc_rd1_addr      = '0;
    dc_wr1_en        = 1'b0;
    dc_wr1_from_mem  = 1'b0;
    dc_wr1_dirty     = 1'b0;
    dc_wr1_valid     = 1'b0;
    dc_wr1_addr      = '0;
    dc_wr1_data      = '0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;

    // Outputs are held quiet while reset is asserted, even with requests pending.
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          dc_rd1_addr = sel_addr;
          dc_wr1_addr = sel_addr;
          if (sel_ld || sel_st) begin
            ld_req_ready = sel_ld;
            st_req_ready = sel_st;
            is_ld_d      = sel_ld;
            addr_d       = sel_addr;
            st_data_d    = st_req_data;
            vic_addr_d   = {dc_evicted_addr[ADDR_W-1:3], 3'b000};
            vic_data_d   = dc_evicted_data;
            vic_dirty_d  = dc_evicted_dirty;
            vic_valid_d  = dc_evicted_valid;
            if (dc_rd1_hit) begin
              if (sel_ld) begin
                resp_vld_d = 1'b1;
                data_d     = dc_rd1_data;
              end else begin
                dc_wr1_en    = 1'b1;
                dc_wr1_dirty = 1'b1;
                dc_wr1_valid = 1'b1;
                dc_wr1_data  = st_req_data;
              end
            end else if (dc_evicted_valid && dc_evicted_dirty) begin
              state_d = S_WB_REQ;
            end else begin
              state_d = sel_ld ? S_FILL_REQ : S_ALLOC;
            end
          end
        end
        S_WB_REQ: begin
          dc_rd1_addr = addr_q;
          dc_wr1_addr = addr_q;
          if (vic_valid_q && vic_dirty_q) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = vic_addr_q;
            proc2mem_data    = vic_data_q;
            if (mem2proc_response != '0) state_d = is_ld_q ? S_FILL_REQ : S_ALLOC;
          end else begin
            state_d = is_ld_q ? S_FILL_REQ : S_ALLOC;
          end
        end
        S_FILL_REQ: begin
          dc_rd1_addr      = addr_q;
          dc_wr1_addr      = addr_q;
          proc2mem_command = BUS_LOAD;
          proc2mem_addr    = addr_q;
          if (mem2proc_response != '0) begin
            tag_d   = mem2proc_response;
            state_d = S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          dc_rd1_addr = addr_q;
          dc_wr1_addr = addr_q;
          if ((tag_q != '0) && (mem2proc_tag == tag_q)) begin
            dc_wr1_en       = 1'b1;
            dc_wr1_from_mem = 1'b1;
            dc_wr1_valid    = 1'b1;
            dc_wr1_data     = mem2proc_data;
            data_d          = mem2proc_data;
            tag_d           = '0;
            state_d         = S_RESP;
          end
        end
        S_ALLOC: begin
          dc_rd1_addr     = addr_q;
          dc_wr1_addr     = addr_q;
          dc_wr1_en       = 1'b1;
          dc_wr1_from_mem = 1'b1;
          dc_wr1_dirty    = 1'b1;
          dc_wr1_valid    = 1'b1;
          dc_wr1_data     = st_data_q;
          state_d         = S_IDLE;
        end
        S_RESP: begin
          dc_rd1_addr = addr_q;
          dc_wr1_addr = addr_q;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      is_ld_q     <= 1'b0;
      addr_q      <= '0;
      st_data_q   <= '0;
      vic_addr_q  <= '0;
      vic_data_q  <= '0;
      vic_dirty_q <= 1'b0;
      vic_valid_q <= 1'b0;
      tag_q       <= '0;
      data_q      <= '0;
      resp_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_ld_q     <= is_ld_d;
      addr_q      <= addr_d;
      st_data_q   <= st_data_d;
      vic_addr_q  <= vic_addr_d;
      vic_data_q  <= vic_data_d;
      vic_dirty_q <= vic_dirty_d;
      vic_valid_q <= vic_valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      resp_vld_q  <= resp_vld_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, clean/dirty misses, tie arbitration,
// foreign memory tags and asynchronous reset during a fill.
module tb_dcache_ctrl;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ld_req_valid;
  logic [AW-1:0] ld_req_addr;
  logic          ld_req_ready;
  logic          ld_resp_valid;
  logic [DW-1:0] ld_resp_data;
  logic          st_req_valid;
  logic [AW-1:0] st_req_addr;
  logic [DW-1:0] st_req_data;
  logic          st_req_ready;
  logic [AW-1:0] dc_rd1_addr;
  logic          dc_rd1_hit;
  logic [DW-1:0] dc_rd1_data;
  logic          dc_wr1_en, dc_wr1_from_mem, dc_wr1_dirty, dc_wr1_valid;
  logic [AW-1:0] dc_wr1_addr;
  logic [DW-1:0] dc_wr1_data;
  logic          dc_evicted_valid, dc_evicted_dirty;
  logic [AW-1:0] dc_evicted_addr;
  logic [DW-1:0] dc_evicted_data;
  logic [1:0]    proc2mem_command;
  logic [AW-1:0] proc2mem_addr;
  logic [DW-1:0] proc2mem_data;
  logic [TW-1:0] mem2proc_response;
  logic [TW-1:0] mem2proc_tag;
  logic [DW-1:0] mem2proc_data;
  logic          busy;

  int n_chk = 0;
  int n_bad = 0;

  dcache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_TAG_W(TW), .LD_PRIORITY(1)) dut (
    .clock(clock), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_ready(st_req_ready),
    .dc_rd1_addr(dc_rd1_addr), .dc_rd1_hit(dc_rd1_hit), .dc_rd1_data(dc_rd1_data),
    .dc_wr1_en(dc_wr1_en), .dc_wr1_from_mem(dc_wr1_from_mem), .dc_wr1_dirty(dc_wr1_dirty),
    .dc_wr1_valid(dc_wr1_valid), .dc_wr1_addr(dc_wr1_addr), .dc_wr1_data(dc_wr1_data),
    .dc_evicted_valid(dc_evicted_valid), .dc_evicted_dirty(dc_evicted_dirty),
    .dc_evicted_addr(dc_evicted_addr), .dc_evicted_data(dc_evicted_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    ld_req_valid = 0; ld_req_addr = '0;
    st_req_valid = 0; st_req_addr = '0; st_req_data = '0;
    dc_rd1_hit = 0; dc_rd1_data = '0;
    dc_evicted_valid = 0; dc_evicted_dirty = 0; dc_evicted_addr = '0; dc_evicted_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  initial begin
    reset = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clock);
    #1;
    // reset: a pending load must not be acknowledged
    ld_req_valid = 1; ld_req_addr = 64'h100;
    @(negedge clock);
    chk("rst_ld_ready", ld_req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", proc2mem_command, 0);
    chk("rst_wr1_en", dc_wr1_en, 0);
    chk("rst_resp_valid", ld_resp_valid, 0);
    ld_req_valid = 0;
    reset = 1'b1;
    tick();

    // cold load miss to 0x100
    ld_req_valid = 1; ld_req_addr = 64'h100;
    @(negedge clock);
    chk("cold_ld_ready", ld_req_ready, 1);
    chk("cold_rd1_addr", dc_rd1_addr, 64'h100);
    tick();
    ld_req_valid = 0;
    @(negedge clock);
    chk("cold_busy", busy, 1);
    chk("cold_cmd_r0", proc2mem_command, 1);
    chk("cold_addr_r0", proc2mem_addr, 64'h100);
    chk("cold_ready_busy", ld_req_ready, 0);
    tick();
    @(negedge clock);
    chk("cold_cmd_r1", proc2mem_command, 1);
    tick();
    mem2proc_response = 3;
    @(negedge clock);
    chk("cold_cmd_r2", proc2mem_command, 1);
    tick();
    mem2proc_response = 0;
    @(negedge clock);
    chk("cold_wait_cmd", proc2mem_command, 0);
    chk("cold_wait_wr1", dc_wr1_en, 0);
    tick();
    mem2proc_tag = 3; mem2proc_data = 64'hDEAD;
    @(negedge clock);
    chk("cold_fill_en", dc_wr1_en, 1);
    chk("cold_fill_mem", dc_wr1_from_mem, 1);
    chk("cold_fill_dirty", dc_wr1_dirty, 0);
    chk("cold_fill_valid", dc_wr1_valid, 1);
    chk("cold_fill_data", dc_wr1_data, 64'hDEAD);
    chk("cold_fill_addr", dc_wr1_addr, 64'h100);
    chk("cold_fill_noresp", ld_resp_valid, 0);
    tick();
    mem2proc_tag = 0; mem2proc_data = '0;
    @(negedge clock);
    chk("cold_resp_valid", ld_resp_valid, 1);
    chk("cold_resp_data", ld_resp_data, 64'hDEAD);
    chk("cold_resp_wr1", dc_wr1_en, 0);
    tick();

    // repeat load hits, response the next cycle
    ld_req_valid = 1; ld_req_addr = 64'h104; dc_rd1_hit = 1; dc_rd1_data = 64'hDEAD;
    @(negedge clock);
    chk("hit_ld_ready", ld_req_ready, 1);
    chk("hit_ld_addr", dc_rd1_addr, 64'h100);
    chk("hit_ld_sameresp", ld_resp_valid, 0);
    tick();
    clr_inputs();
    @(negedge clock);
    chk("hit_resp_valid", ld_resp_valid, 1);
    chk("hit_resp_data", ld_resp_data, 64'hDEAD);
    chk("hit_busy", busy, 0);
    tick();

    // store hit
    st_req_valid = 1; st_req_addr = 64'h100; st_req_data = 64'h55; dc_rd1_hit = 1;
    @(negedge clock);
    chk("sth_ready", st_req_ready, 1);
    chk("sth_en", dc_wr1_en, 1);
    chk("sth_mem", dc_wr1_from_mem, 0);
    chk("sth_dirty", dc_wr1_dirty, 1);
    chk("sth_data", dc_wr1_data, 64'h55);
    chk("sth_cmd", proc2mem_command, 0);
    tick();
    clr_inputs();
    @(negedge clock);
    chk("sth_after_busy", busy, 0);
    chk("sth_after_en", dc_wr1_en, 0);
    tick();

    // load miss with dirty victim
    ld_req_valid = 1; ld_req_addr = 64'h300;
    dc_evicted_valid = 1; dc_evicted_dirty = 1; dc_evicted_addr = 64'h900; dc_evicted_data = 64'h55;
    @(negedge clock);
    chk("dv_ready", ld_req_ready, 1);
    tick();
    clr_inputs();
    @(negedge clock);
    chk("dv_wb_cmd0", proc2mem_command, 2);
    chk("dv_wb_addr", proc2mem_addr, 64'h900);
    chk("dv_wb_data", proc2mem_data, 64'h55);
    chk("dv_wb_wr1addr", dc_wr1_addr, 64'h300);
    tick();
    mem2proc_response = 1;
    @(negedge clock);
    chk("dv_wb_cmd1", proc2mem_command, 2);
    tick();
    mem2proc_response = 2;
    @(negedge clock);
    chk("dv_fill_cmd", proc2mem_command, 1);
    chk("dv_fill_addr", proc2mem_addr, 64'h300);
    tick();
    mem2proc_response = 0; mem2proc_tag = 2; mem2proc_data = 64'h77;
    @(negedge clock);
    chk("dv_fill_en", dc_wr1_en, 1);
    chk("dv_fill_wraddr", dc_wr1_addr, 64'h300);
    tick();
    clr_inputs();
    @(negedge clock);
    chk("dv_resp_data", ld_resp_data, 64'h77);
    chk("dv_resp_valid", ld_resp_valid, 1);
    tick();

    // store miss, clean victim
    st_req_valid = 1; st_req_addr = 64'h400; st_req_data = 64'hAB;
    dc_evicted_valid = 1; dc_evicted_dirty = 0; dc_evicted_addr = 64'hA00;
    @(negedge clock);
    chk("sm_ready", st_req_ready, 1);
    chk("sm_cmd0", proc2mem_command, 0);
    chk("sm_en0", dc_wr1_en, 0);
    tick();
    clr_inputs();
    @(negedge clock);
    chk("sm_alloc_en", dc_wr1_en, 1);
    chk("sm_alloc_mem", dc_wr1_from_mem, 1);
    chk("sm_alloc_dirty", dc_wr1_dirty, 1);
    chk("sm_alloc_data", dc_wr1_data, 64'hAB);
    chk("sm_alloc_addr", dc_wr1_addr, 64'h400);
    chk("sm_alloc_cmd", proc2mem_command, 0);
    tick();
    @(negedge clock);
    chk("sm_idle_busy", busy, 0);
    chk("sm_idle_en", dc_wr1_en, 0);
    tick();

    // same-block load/store tie, load wins
    ld_req_valid = 1; ld_req_addr = 64'h200;
    st_req_valid = 1; st_req_addr = 64'h200; st_req_data = 64'h99;
    @(negedge clock);
    chk("tie_ld_ready", ld_req_ready, 1);
    chk("tie_st_ready", st_req_ready, 0);
    tick();
    ld_req_valid = 0; mem2proc_response = 2;
    @(negedge clock);
    chk("tie_st_wait0", st_req_ready, 0);
    chk("tie_cmd", proc2mem_command, 1);
    chk("tie_addr", proc2mem_addr, 64'h200);
    tick();
    mem2proc_response = 0; mem2proc_tag = 5; mem2proc_data = 64'hBAD;
    @(negedge clock);
    chk("tie_foreign_en", dc_wr1_en, 0);
    chk("tie_st_wait1", st_req_ready, 0);
    tick();
    mem2proc_tag = 2; mem2proc_data = 64'h1234;
    @(negedge clock);
    chk("tie_fill_en", dc_wr1_en, 1);
    chk("tie_fill_data", dc_wr1_data, 64'h1234);
    tick();
    mem2proc_tag = 0; mem2proc_data = '0;
    @(negedge clock);
    chk("tie_resp_data", ld_resp_data, 64'h1234);
    chk("tie_st_wait2", st_req_ready, 0);
    tick();
    dc_rd1_hit = 1;
    @(negedge clock);
    chk("tie_st_ready", st_req_ready, 1);
    chk("tie_st_en", dc_wr1_en, 1);
    chk("tie_st_data", dc_wr1_data, 64'h99);
    tick();
    clr_inputs();

    // reset during FILL_WAIT
    ld_req_valid = 1; ld_req_addr = 64'h500;
    tick();
    ld_req_valid = 0; mem2proc_response = 4;
    tick();
    mem2proc_response = 0;
    @(negedge clock);
    chk("rfw_busy_pre", busy, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("rfw_busy", busy, 0);
    chk("rfw_cmd", proc2mem_command, 0);
    tick();
    reset = 1'b1;
    mem2proc_tag = 4; mem2proc_data = 64'hCAFE;
    @(negedge clock);
    chk("rfw_late_en", dc_wr1_en, 0);
    tick();
    mem2proc_tag = 0;
    @(negedge clock);
    chk("rfw_late_resp", ld_resp_valid, 0);
    chk("rfw_late_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
